// File: rtl/mem_responder.sv
// Wait-state memory responder: level-sensitive read/write requests, one-cycle ready pulse.
// Optional MEM_RESP_INIT_EN adds a CLEAR state that zeroes the memory after reset.
module mem_responder #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_ready,
    output logic              mem_busy,
    output logic              mem_err
);

    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    localparam logic [2:0]  WAIT_LD = 3'(WAIT_CYC);

`ifdef MEM_RESP_INIT_EN
    typedef enum logic [1:0] {IDLE, WAIT, DONE, CLEAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
`endif

    state_t            state, state_d;
    logic [2:0]        cnt, cnt_d;
    logic              op_wr, op_wr_d;
    logic [ADDR_W-1:0] lat_addr, lat_addr_d;
    logic [DATA_W-1:0] lat_wdata, lat_wdata_d;
    logic              err_d;
    logic              we, re;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [DATA_W-1:0] mem [DEPTH];
`ifdef MEM_RESP_INIT_EN
    logic [ADDR_W-1:0] clr_addr, clr_addr_d;
`endif

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        op_wr_d     = op_wr;
        lat_addr_d  = lat_addr;
        lat_wdata_d = lat_wdata;
        err_d       = 1'b0;
        we          = 1'b0;
        re          = 1'b0;
        acc_addr    = lat_addr;
        acc_wdata   = lat_wdata;
        mem_busy    = (state != IDLE);
        mem_ready   = (state == DONE);
`ifdef MEM_RESP_INIT_EN
        clr_addr_d  = clr_addr;
`endif
        case (state)
            IDLE: begin
                if (mem_rd && mem_wr) begin
                    err_d = 1'b1;
                end else if (mem_rd || mem_wr) begin
                    op_wr_d     = mem_wr;
                    lat_addr_d  = addr;
                    lat_wdata_d = wdata;
                    // zero wait states: the access happens on the request edge itself
                    if (WAIT_CYC == 0) begin
                        state_d   = DONE;
                        we        = mem_wr;
                        re        = mem_rd;
                        acc_addr  = addr;
                        acc_wdata = wdata;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LD;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    state_d = DONE;
                    we      = op_wr;
                    re      = !op_wr;
                end
            end
            DONE: state_d = IDLE;
`ifdef MEM_RESP_INIT_EN
            CLEAR: begin
                we         = 1'b1;
                acc_addr   = clr_addr;
                acc_wdata  = '0;
                clr_addr_d = clr_addr + 1'b1;
                if (clr_addr == '1) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
`ifdef MEM_RESP_INIT_EN
            state    <= CLEAR;
            clr_addr <= '0;
`else
            state    <= IDLE;
`endif
            cnt     <= '0;
            rdata   <= '0;
            mem_err <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            op_wr     <= op_wr_d;
            lat_addr  <= lat_addr_d;
            lat_wdata <= lat_wdata_d;
            mem_err   <= err_d;
`ifdef MEM_RESP_INIT_EN
            clr_addr  <= clr_addr_d;
`endif
            if (re) rdata <= mem[acc_addr];
        end
    end

    // Memory is never reset; a reset edge only suppresses the pending write.
    always_ff @(posedge clock) begin
        if (we && !reset) mem[acc_addr] <= acc_wdata;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: WAIT_CYC=2 and WAIT_CYC=0 instances, scoreboard of read data.
// Covers MEM_RESP_INIT_EN clear behaviour when that macro is defined.
module tb_mem_responder;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
`ifdef MEM_RESP_INIT_EN
    localparam bit INIT = 1'b1;
`else
    localparam bit INIT = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          rd2, wr2, rd0, wr0;
    logic [AW-1:0] addr2, addr0;
    logic [DW-1:0] wdata2, wdata0, rdata2, rdata0;
    logic          ready2, busy2, err2, ready0, busy0, err0;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ref_mem2 [16];
    logic [DW-1:0] ref_mem0 [16];
    logic [DW-1:0] q2 [$];
    logic [DW-1:0] q0 [$];
    logic [DW-1:0] exp_rdata2;

    always #5 clock = ~clock;

    mem_responder #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYC(2)) u_w2 (
        .clock(clock), .reset(reset), .mem_rd(rd2), .mem_wr(wr2), .addr(addr2),
        .wdata(wdata2), .rdata(rdata2), .mem_ready(ready2), .mem_busy(busy2), .mem_err(err2)
    );

    mem_responder #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYC(0)) u_w0 (
        .clock(clock), .reset(reset), .mem_rd(rd0), .mem_wr(wr0), .addr(addr0),
        .wdata(wdata0), .rdata(rdata0), .mem_ready(ready0), .mem_busy(busy0), .mem_err(err0)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_refs();
        for (int i = 0; i < 16; i++) begin
            ref_mem2[i] = '0;
            ref_mem0[i] = '0;
        end
    endtask

    // One WAIT_CYC=2 access with the request held for a single cycle.
    task automatic access2(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int lat = 0;
        int busy_cnt = 0;
        rd2 = !wr; wr2 = wr; addr2 = a; wdata2 = d;
        if (!wr) q2.push_back(ref_mem2[a]);
        tick();
        rd2 = 1'b0; wr2 = 1'b0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            if (busy2) busy_cnt++;
            if (ready2) begin
                lat = k;
                if (!wr) exp_rdata2 = q2.pop_front();
                checks++;
                if (rdata2 !== exp_rdata2) begin
                    errors++;
                    $display("FAIL access_rdata wr=%0d addr=%0d got=%h exp=%h", wr, a, rdata2, exp_rdata2);
                end
            end
            tick();
        end
        if (!wr && lat == 0) q2.delete();
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL access_latency wr=%0d addr=%0d got=%0d exp=3 (0 = timeout)", wr, a, lat);
        end
        checks++;
        if (busy_cnt != 3) begin
            errors++;
            $display("FAIL access_busy_cycles wr=%0d got=%0d exp=3", wr, busy_cnt);
        end
        checks++;
        if (busy2 !== 1'b0) begin
            errors++;
            $display("FAIL access_busy_after got=%b exp=0", busy2);
        end
        if (wr && lat != 0) ref_mem2[a] = d;
    endtask

    task automatic test_reset();
        rd2 = 0; wr2 = 0; rd0 = 0; wr0 = 0;
        addr2 = '0; addr0 = '0; wdata2 = '0; wdata0 = '0;
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (rdata2 !== '0 || ready2 !== 1'b0 || err2 !== 1'b0 || busy2 !== INIT) begin
            errors++;
            $display("FAIL reset_w2 rdata=%h ready=%b err=%b busy=%b exp 00/0/0/%b", rdata2, ready2, err2, busy2, INIT);
        end
        checks++;
        if (rdata0 !== '0 || ready0 !== 1'b0 || err0 !== 1'b0 || busy0 !== INIT) begin
            errors++;
            $display("FAIL reset_w0 rdata=%h ready=%b err=%b busy=%b exp 00/0/0/%b", rdata0, ready0, err0, busy0, INIT);
        end
        reset = 1'b0;
        exp_rdata2 = '0;
        if (INIT) clear_refs();
        for (int k = 0; k < 40 && busy2; k++) tick();
        checks++;
        if (busy2 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_settle busy2=%b busy0=%b exp 0/0", busy2, busy0);
        end
    endtask

    task automatic test_write_read();
        access2(1'b1, 4'd5, 8'h11);
        access2(1'b1, 4'd3, 8'hA5);
        access2(1'b0, 4'd3, 8'h00);
        rd2 = 1'b0;
        repeat (3) tick();
        checks++;
        if (rdata2 !== 8'hA5) begin
            errors++;
            $display("FAIL rdata_hold got=%h exp=a5", rdata2);
        end
    endtask

    task automatic test_conflict();
        rd2 = 1'b1; wr2 = 1'b1; addr2 = 4'd3; wdata2 = 8'h77;
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 2) begin rd2 = 1'b0; wr2 = 1'b0; end
            checks++;
            if (err2 !== (k <= 2) || busy2 !== 1'b0 || ready2 !== 1'b0) begin
                errors++;
                $display("FAIL conflict_cycle%0d err=%b busy=%b ready=%b exp %b/0/0", k, err2, busy2, ready2, (k <= 2));
            end
        end
        access2(1'b0, 4'd3, 8'h00);
    endtask

    task automatic test_reset_abort();
        int pulses = 0;
        wr2 = 1'b1; addr2 = 4'd5; wdata2 = 8'h3C;
        tick();
        wr2 = 1'b0;
        checks++;
        if (busy2 !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_wait busy=%b exp=1", busy2);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_rdata2 = '0;
        if (INIT) clear_refs();
        checks++;
        if (busy2 !== INIT || ready2 !== 1'b0 || rdata2 !== '0) begin
            errors++;
            $display("FAIL abort_after_reset busy=%b ready=%b rdata=%h exp %b/0/00", busy2, ready2, rdata2, INIT);
        end
        for (int k = 0; k < 20; k++) begin
            if (ready2) pulses++;
            tick();
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL abort_no_ready pulses=%0d exp=0", pulses);
        end
        access2(1'b0, 4'd5, 8'h00);
    endtask

    task automatic test_zero_wait();
        logic [7:0] seen = '0;
        int pulses = 0;
        logic [DW-1:0] exp;
        wr0 = 1'b1; addr0 = 4'd7; wdata0 = 8'h5A;
        tick();
        wr0 = 1'b0;
        checks++;
        if (ready0 !== 1'b1 || busy0 !== 1'b1 || rdata0 !== '0) begin
            errors++;
            $display("FAIL zw_write ready=%b busy=%b rdata=%h exp 1/1/00", ready0, busy0, rdata0);
        end
        tick();
        checks++;
        if (ready0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL zw_write_idle ready=%b busy=%b exp 0/0", ready0, busy0);
        end
        ref_mem0[7] = 8'h5A;
        rd0 = 1'b1; addr0 = 4'd7;
        q0.push_back(ref_mem0[7]);
        q0.push_back(ref_mem0[7]);
        for (int k = 0; k < 7; k++) begin
            tick();
            if (k == 3) rd0 = 1'b0;
            if (ready0) begin
                pulses++;
                seen[k+1] = 1'b1;
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL zw_extra_ready cycle=%0d got=1 exp=0", k + 1);
                end else begin
                    exp = q0.pop_front();
                    if (rdata0 !== exp) begin
                        errors++;
                        $display("FAIL zw_rdata cycle=%0d got=%h exp=%h", k + 1, rdata0, exp);
                    end
                end
            end
        end
        checks++;
        if (pulses != 2 || seen !== 8'b0000_1010) begin
            errors++;
            $display("FAIL zw_ready_pattern pulses=%0d mask=%b exp 2/00001010", pulses, seen);
        end
    endtask

`ifdef MEM_RESP_INIT_EN
    task automatic test_init_clear();
        int busy_cnt = 0;
        int rdy = 0;
        access2(1'b1, 4'd15, 8'hFF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_rdata2 = '0;
        rd2 = 1'b1; addr2 = 4'd15;
        for (int k = 0; k < 40 && busy2; k++) begin
            busy_cnt++;
            if (ready2) rdy++;
            tick();
            rd2 = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            if (ready2 || busy2) rdy++;
            tick();
        end
        clear_refs();
        checks++;
        if (busy_cnt != 16) begin
            errors++;
            $display("FAIL clear_busy_cycles got=%0d exp=16", busy_cnt);
        end
        checks++;
        if (rdy != 0 || rdata2 !== '0) begin
            errors++;
            $display("FAIL clear_read_ignored activity=%0d rdata=%h exp 0/00", rdy, rdata2);
        end
        access2(1'b0, 4'd15, 8'h00);
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_conflict();
        test_reset_abort();
        test_zero_wait();
`ifdef MEM_RESP_INIT_EN
        test_init_clear();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
